// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch bundle: operands, hazard
// sources, and resolution/statistics outputs.
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       operation_i;
  logic             equal_i;
  logic [4:0]       rs_i;
  logic [4:0]       rt_i;
  logic             ex_regwrite_i;
  logic             ex_memread_i;
  logic [4:0]       ex_rd_i;
  logic             mem_memread_i;
  logic [4:0]       mem_rd_i;
  logic [31:0]      pc_plus4_i;
  logic [31:0]      imm_i;
  logic             stall_o;
  logic             pc_src_o;
  logic             flush_o;
  logic [31:0]      target_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  modport master (
    output operation_i, equal_i, rs_i, rt_i,
    output ex_regwrite_i, ex_memread_i, ex_rd_i,
    output mem_memread_i, mem_rd_i,
    output pc_plus4_i, imm_i,
    input  stall_o, pc_src_o, flush_o, target_o,
    input  branch_cnt_o, taken_cnt_o
  );

  modport slave (
    input  operation_i, equal_i, rs_i, rt_i,
    input  ex_regwrite_i, ex_memread_i, ex_rd_i,
    input  mem_memread_i, mem_rd_i,
    input  pc_plus4_i, imm_i,
    output stall_o, pc_src_o, flush_o, target_o,
    output branch_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage beq resolver: hazard stalls, PC select,
// target, IF/ID flush, branch/taken counters.
// Ports: clk_i, rst_i (sync, active-high), bus.
module branch_resolve_unit #(
  parameter logic [3:0] BRANCH_OP = 4'b0111,
  parameter int         CNT_W     = 16
) (
  input logic clk_i,
  input logic rst_i,
  branch_resolve_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    EVAL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] br_cnt, tk_cnt;
  logic             br, hit_ex, hit_mem;
  logic [1:0]       n;
  logic             stall, resolve;

  assign br = bus.operation_i == BRANCH_OP;

  // register 0 is never a real producer
  assign hit_ex = (bus.ex_rd_i != 5'd0) &&
    ((bus.ex_rd_i == bus.rs_i) ||
     (bus.ex_rd_i == bus.rt_i));
  assign hit_mem = (bus.mem_rd_i != 5'd0) &&
    ((bus.mem_rd_i == bus.rs_i) ||
     (bus.mem_rd_i == bus.rt_i));

  always_comb begin
    n = 2'd0;
    if (bus.ex_memread_i && hit_ex)
      n = 2'd2;
    else if ((bus.ex_regwrite_i && hit_ex) ||
             (bus.mem_memread_i && hit_mem))
      n = 2'd1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    resolve   = 1'b0;
    unique case (state)
      IDLE: begin
        if (br) begin
          if (n == 2'd0) begin
            resolve = 1'b1;
          end else begin
            stall     = 1'b1;
            cnt_nxt   = n - 2'd1;
            state_nxt = (n == 2'd1) ? EVAL : STALL;
          end
        end
      end
      STALL: begin
        stall   = 1'b1;
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1)
          state_nxt = EVAL;
      end
      EVAL: begin
        resolve   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      br_cnt <= '0;
      tk_cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (resolve) begin
        if (br_cnt != CMAX)
          br_cnt <= br_cnt + 1'b1;
        if (bus.equal_i && tk_cnt != CMAX)
          tk_cnt <= tk_cnt + 1'b1;
      end
    end
  end

  assign bus.stall_o  = stall & ~rst_i;
  assign bus.pc_src_o = resolve & bus.equal_i & ~rst_i;
  assign bus.flush_o  = resolve & bus.equal_i & ~rst_i;
  assign bus.target_o = bus.pc_plus4_i +
                        {bus.imm_i[29:0], 2'b00};
  assign bus.branch_cnt_o = br_cnt;
  assign bus.taken_cnt_o  = tk_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit:
// directed plan steps, random traffic, saturation.
module tb_branch_resolve_unit;

  localparam logic [3:0] BOP = 4'b0111;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int total = 0;
  int bad = 0;

  // reference model: cycles left until resolve,
  // plus plain integer statistics
  int m_wait = 0;
  int m_br = 0;
  int m_tk = 0;

  branch_resolve_unit_if #(.CNT_W(CW)) bus ();

  branch_resolve_unit #(
    .BRANCH_OP(BOP),
    .CNT_W(CW)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic int hz_n();
    bit exm, memm;
    exm = bus.ex_rd_i != 0 &&
      (bus.ex_rd_i == bus.rs_i ||
       bus.ex_rd_i == bus.rt_i);
    memm = bus.mem_rd_i != 0 &&
      (bus.mem_rd_i == bus.rs_i ||
       bus.mem_rd_i == bus.rt_i);
    if (bus.ex_memread_i && exm) return 2;
    if ((bus.ex_regwrite_i && exm) ||
        (bus.mem_memread_i && memm)) return 1;
    return 0;
  endfunction

  task automatic clr();
    bus.operation_i   = 4'd0;
    bus.equal_i       = 1'b0;
    bus.rs_i          = 5'd0;
    bus.rt_i          = 5'd0;
    bus.ex_regwrite_i = 1'b0;
    bus.ex_memread_i  = 1'b0;
    bus.ex_rd_i       = 5'd0;
    bus.mem_memread_i = 1'b0;
    bus.mem_rd_i      = 5'd0;
  endtask

  // inputs are set just after an edge; check
  // mid-cycle, then advance the model on the edge
  task automatic tick();
    bit is_br, e_st, e_res;
    int n;
    logic [31:0] e_tgt;
    is_br = bus.operation_i == BOP;
    n = hz_n();
    e_st = 0;
    e_res = 0;
    if (!rst_i) begin
      if (m_wait == 0) begin
        if (is_br && n == 0) e_res = 1;
        if (is_br && n > 0) e_st = 1;
      end else if (m_wait == 1) begin
        e_res = 1;
      end else begin
        e_st = 1;
      end
    end
    e_tgt = bus.pc_plus4_i + bus.imm_i * 4;
    #4;
    chk("stall", 32'(bus.stall_o), 32'(e_st));
    chk("pc_src", 32'(bus.pc_src_o),
        32'(e_res && bus.equal_i));
    chk("flush", 32'(bus.flush_o),
        32'(e_res && bus.equal_i));
    chk("target", bus.target_o, e_tgt);
    chk("branch_cnt", 32'(bus.branch_cnt_o),
        32'(m_br));
    chk("taken_cnt", 32'(bus.taken_cnt_o),
        32'(m_tk));
    @(posedge clk_i);
    if (rst_i) begin
      m_wait = 0;
      m_br = 0;
      m_tk = 0;
    end else begin
      if (e_res) begin
        if (m_br < CMAX) m_br++;
        if (bus.equal_i && m_tk < CMAX) m_tk++;
      end
      if (m_wait > 0) m_wait--;
      else if (is_br && n > 0) m_wait = n;
    end
    #1;
  endtask

  initial begin
    clr();
    bus.pc_plus4_i = 32'h0;
    bus.imm_i = 32'h0;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    tick();
    rst_i = 1'b0;
    bus.operation_i = 4'd3;
    repeat (3) tick();

    // no-hazard taken branch
    bus.operation_i = BOP;
    bus.equal_i = 1'b1;
    bus.pc_plus4_i = 32'h100;
    bus.imm_i = 32'h4;
    #2;
    chk("tgt_0x110", bus.target_o, 32'h110);
    chk("pc_src_n0", 32'(bus.pc_src_o), 32'd1);
    #1;
    tick();
    clr();
    tick();
    chk("br_cnt_1", 32'(bus.branch_cnt_o), 32'd1);

    // load in EX feeds rs: two stalls
    bus.operation_i = BOP;
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i = 5'd5;
    bus.rs_i = 5'd5;
    bus.rt_i = 5'd9;
    repeat (3) tick();
    clr();
    tick();

    // ALU result in EX feeds rt: one stall
    bus.operation_i = BOP;
    bus.ex_regwrite_i = 1'b1;
    bus.ex_rd_i = 5'd7;
    bus.rt_i = 5'd7;
    bus.equal_i = 1'b1;
    repeat (2) tick();
    bus.ex_rd_i = 5'd0;
    tick();
    clr();
    tick();

    // negative offset wraps
    bus.pc_plus4_i = 32'h4;
    bus.imm_i = 32'hFFFF_FFFE;
    #2;
    chk("tgt_wrap", bus.target_o, 32'hFFFF_FFFC);
    #1;
    tick();

    // reset during an N=2 stall aborts it
    bus.operation_i = BOP;
    bus.ex_memread_i = 1'b1;
    bus.ex_rd_i = 5'd3;
    bus.rt_i = 5'd3;
    bus.equal_i = 1'b1;
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clr();
    tick();
    chk("abort_cnt", 32'(bus.branch_cnt_o), 32'd0);
    tick();

    // random traffic; IF/ID stays held while
    // the model waits, hazards may change
    for (int i = 0; i < 600; i++) begin
      if (m_wait == 0) begin
        bus.operation_i = ($urandom_range(1, 0) != 0)
          ? BOP : 4'($urandom_range(6, 0));
        bus.rs_i = 5'($urandom_range(3, 0));
        bus.rt_i = 5'($urandom_range(3, 0));
        bus.pc_plus4_i = $urandom;
        bus.imm_i = $urandom;
      end
      bus.equal_i = (bus.operation_i == BOP) &&
                    ($urandom_range(1, 0) != 0);
      bus.ex_regwrite_i = 1'($urandom);
      bus.ex_memread_i = 1'($urandom);
      bus.ex_rd_i = 5'($urandom_range(3, 0));
      bus.mem_memread_i = 1'($urandom);
      bus.mem_rd_i = 5'($urandom_range(3, 0));
      rst_i = $urandom_range(39, 0) == 0;
      tick();
    end
    rst_i = 1'b0;
    clr();
    tick();

    // saturation after a fresh reset
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    bus.operation_i = BOP;
    bus.equal_i = 1'b1;
    for (int i = 0; i < 65537; i++) tick();
    clr();
    tick();
    chk("sat_br", 32'(bus.branch_cnt_o), 32'hFFFF);
    chk("sat_tk", 32'(bus.taken_cnt_o), 32'hFFFF);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

ID-stage branch controller for the 5-stage pipeline. It consumes the equality flag from the ID-stage register comparator and resolves `beq` in ID. It inserts the stall cycles needed when a branch source register is still being produced in EX or MEM. Once the operands are valid, it drives PC select, the branch target and the IF/ID flush, and keeps taken and total branch counters for performance checks.

## Interface
Parameters:
- `BRANCH_OP`, 4'b0111: operation code identifying `beq`.
- `CNT_W`, 16: width of the branch statistics counters.

Ports:
- `clk_i`  in  1  — single clock; all state updates on the rising edge.
- `rst_i`  in  1  — reset, synchronous, active-high.
- `operation_i`  in  4  — decoded operation of the instruction in ID.
- `equal_i`  in  1  — 1 when the two ID operands are equal and `operation_i`==BRANCH_OP.
- `rs_i`, `rt_i`  in  5 each  — source register numbers of the ID instruction.
- `ex_regwrite_i`  in  1  — EX instruction writes a register.
- `ex_memread_i`  in  1  — EX instruction is a load.
- `ex_rd_i`  in  5  — EX destination register.
- `mem_memread_i`  in  1  — MEM instruction is a load.
- `mem_rd_i`  in  5  — MEM destination register.
- `pc_plus4_i`  in  32  — PC+4 of the ID instruction.
- `imm_i`  in  32  — sign-extended immediate of the ID instruction.
- `stall_o`  out  1  — hold PC and IF/ID; zero the ID/EX control bits.
- `pc_src_o`  out  1  — 1 selects `target_o` as the next PC.
- `flush_o`  out  1  — zero IF/ID on the next edge.
- `target_o`  out  32  — branch target.
- `branch_cnt_o`  out  CNT_W  — resolved branches.
- `taken_cnt_o`  out  CNT_W  — taken branches.

## Operation
- Branch: `br` = (`operation_i`==BRANCH_OP).
- Hazard cycle count N, computed in IDLE; register 0 never matches:
  - N=2 if `ex_memread_i` and `ex_rd_i`≠0 and `ex_rd_i` equals `rs_i` or `rt_i`.
  - Otherwise N=1 if (`ex_regwrite_i` and the same EX match), or (`mem_memread_i` and `mem_rd_i`≠0 and `mem_rd_i` equals `rs_i` or `rt_i`).
  - Otherwise N=0.
- `target_o` = `pc_plus4_i` + (`imm_i`<<2), computed as a 32-bit add with wrap-around and no overflow flag. It is always driven, independent of state.
- FSM states are IDLE, STALL and EVAL. A 2-bit down-counter `cnt` tracks remaining stall cycles.
  - **IDLE:**
    - `br` and N=0: resolve this cycle (see below); stay in IDLE.
    - `br` and N>0: `stall_o`=1; `cnt`<=N-1; go to EVAL if N=1, otherwise to STALL.
    - Not `br`: all outputs 0.
  - **STALL:** `stall_o`=1; `cnt`<=`cnt`-1; go to EVAL when `cnt`==1. Hazard inputs are ignored in this state.
  - **EVAL:** `stall_o`=0; resolve using the current `equal_i`; hazard inputs are ignored; go to IDLE.
- Resolve:
  - `pc_src_o`=`flush_o`=`equal_i`.
  - `branch_cnt_o` increments.
  - `taken_cnt_o` increments if `equal_i`.
  - Both counters saturate at all-ones; they do not wrap.
- `stall_o`, `pc_src_o` and `flush_o` are combinational from state and inputs (Mealy). `stall_o` and `pc_src_o` are never both 1.

## Timing
- Reset: while `rst_i`=1, `stall_o`, `pc_src_o` and `flush_o` are forced to 0. On the next edge the state is IDLE, `cnt`=0 and both counters are 0.
- Reset during STALL or EVAL aborts the branch: no counter update, no `pc_src_o`.
- Latency from the first cycle the branch is in ID (cycle 0) to resolution:
  - N=0: cycle 0.
  - N=1: cycle 1.
  - N=2: cycle 2.
- `stall_o` is high for exactly N consecutive cycles, cycles 0..N-1.
- Counters are registered and become visible the cycle after resolution.
- A branch that appears in ID on the cycle right after EVAL is handled by IDLE with no bubble.
- A non-branch `operation_i` in STALL or EVAL cannot occur because IF/ID is held. If it does occur, EVAL still resolves with `equal_i`, which is then 0, so the branch counts as not taken.

## Test plan
- Reset then idle: `rst_i`=1 for 2 cycles, then non-branch ops → all outputs 0; both counters 0.
- No-hazard taken branch: `br`, N=0, `equal_i`=1, `pc_plus4_i`=0x100, `imm_i`=0x4 → same cycle `pc_src_o`=`flush_o`=1, `target_o`=0x110, `stall_o`=0; next cycle branch_cnt=1, taken_cnt=1.
- Load in EX feeds `rs_i`: `ex_memread_i`=1, `ex_rd_i`=`rs_i`=5 → `stall_o`=1 in cycles 0 and 1. Cycle 2 with `equal_i`=0 → `pc_src_o`=0, `flush_o`=0; branch_cnt increments, taken_cnt does not.
- ALU in EX writes `rt_i`=7: N=1 → one stall cycle; resolve at cycle 1 with `equal_i`=1 → `pc_src_o`=1. Repeat with `ex_rd_i`=0 → N=0, no stall.
- Negative offset wrap: `pc_plus4_i`=0x4, `imm_i`=0xFFFFFFFE → `target_o`=0xFFFFFFFC.
- Reset mid-stall and saturation: assert `rst_i` in cycle 1 of an N=2 stall → no resolve, counters 0, IDLE. Then run 65537 taken branches → both counters hold 0xFFFF.
